// File: rtl/reg_addr_sequencer.sv
// ---------------------------------------------------------------------------
// reg_addr_sequencer
//
// Captures an instruction word and a select code, then issues one or more
// register-file addresses over a valid/ready stream. Single-register selects
// (Rn, Rd, PC) produce one beat. The register-list select produces one beat
// per set bit of ir[NREG-1:0], at one beat per clock while the consumer is ready.
//
// Optional feature macro: REG_ADDR_DESCEND_EN
//   defined   : for sel=3, ir[23]==0 scans the highest set bit first and
//               ir[23]==1 scans the lowest set bit first.
//   undefined : ir[23] is ignored and the list is always scanned ascending.
//
// Ports
//   clk         in   1      clock, rising edge
//   reset       in   1      synchronous, active-high reset
//   ir          in   IRW    instruction word, sampled when a load is accepted
//   sel         in   2      0=Rn ir[19:16], 1=Rd ir[15:12], 2=PC_IDX, 3=list
//   load        in   1      request, accepted when load && !busy
//   out_ready   in   1      consumer accepts addr this cycle
//   addr        out  AW     registered register address
//   addr_valid  out  1      addr is valid
//   last        out  1      current beat is the final beat of the request
//   busy        out  1      request in progress, new loads ignored
//   empty_list  out  1      sel=3 request had no bits set (sticky until next load)
//   beats       out  AW+1   beats completed for the current/last request
// ---------------------------------------------------------------------------
module reg_addr_sequencer #(
  parameter int AW     = 4,
  parameter int IRW    = 32,
  parameter int PC_IDX = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IRW-1:0] ir,
  input  logic [1:0]     sel,
  input  logic           load,
  input  logic           out_ready,
  output logic [AW-1:0]  addr,
  output logic           addr_valid,
  output logic           last,
  output logic           busy,
  output logic           empty_list,
  output logic [AW:0]    beats
);

  localparam int NREG = 1 << AW;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state_reg;
  logic [NREG-1:0]   mask_reg;
  logic [NREG-1:0]   mask_next;
  logic [AW-1:0]     addr_reg;
  logic              addr_valid_reg;
  logic              last_reg;
  logic              busy_reg;
  logic              empty_list_reg;
  logic [AW:0]       beats_reg;
  logic              desc_reg;
  logic              load_desc;
  logic [NREG-1:0]   list_bits;
  logic              handshake;
  logic              unused_ir;

  assign list_bits = ir[NREG-1:0];
  assign handshake = addr_valid_reg && out_ready;
  assign unused_ir = ^ir;

  // Mask with the bit of the address currently on the bus removed; this is
  // what remains after the current beat is accepted.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_clear
      assign mask_next[gi] = mask_reg[gi] && (addr_reg != AW'(gi));
    end
  endgenerate

  // Index of the lowest (desc=0) or highest (desc=1) set bit; 0 for an empty mask.
  function automatic logic [AW-1:0] pick(input logic [NREG-1:0] m, input logic desc);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (!desc && m[i]) idx = AW'(i);
    end
    for (int i = 0; i < NREG; i++) begin
      if (desc && m[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  function automatic logic exactly_one(input logic [NREG-1:0] m);
    return (m != '0) && ((m & (m - NREG'(1))) == '0);
  endfunction

`ifdef REG_ADDR_DESCEND_EN
  // ir[23]==0 means a downward scan, so the highest index goes first.
  assign load_desc = ~ir[23];

  always_ff @(posedge clk) begin
    if (reset) begin
      desc_reg <= 1'b0;
    end else if (state_reg == IDLE && load) begin
      desc_reg <= load_desc;
    end
  end
`else
  assign load_desc = 1'b0;
  assign desc_reg  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mask_reg       <= '0;
      addr_reg       <= '0;
      addr_valid_reg <= 1'b0;
      last_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      empty_list_reg <= 1'b0;
      beats_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            state_reg      <= ISSUE;
            busy_reg       <= 1'b1;
            addr_valid_reg <= 1'b1;
            beats_reg      <= '0;
            empty_list_reg <= 1'b0;
            mask_reg       <= '0;
            last_reg       <= 1'b1;
            case (sel)
              2'd0: addr_reg <= ir[16 +: AW];
              2'd1: addr_reg <= ir[12 +: AW];
              2'd2: addr_reg <= AW'(PC_IDX);
              default: begin
                if (list_bits == '0) begin
                  // Empty list degenerates to a single PC beat.
                  addr_reg       <= AW'(PC_IDX);
                  empty_list_reg <= 1'b1;
                end else begin
                  mask_reg <= list_bits;
                  addr_reg <= pick(list_bits, load_desc);
                  last_reg <= exactly_one(list_bits);
                end
              end
            endcase
          end
        end
        ISSUE: begin
          if (handshake) begin
            beats_reg <= beats_reg + (AW+1)'(1);
            if (last_reg) begin
              state_reg      <= IDLE;
              busy_reg       <= 1'b0;
              addr_valid_reg <= 1'b0;
              last_reg       <= 1'b0;
              mask_reg       <= '0;
            end else begin
              // Only list requests reach here; present the next set bit at once.
              mask_reg <= mask_next;
              addr_reg <= pick(mask_next, desc_reg);
              last_reg <= exactly_one(mask_next);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign addr       = addr_reg;
  assign addr_valid = addr_valid_reg;
  assign last       = last_reg;
  assign busy       = busy_reg;
  assign empty_list = empty_list_reg;
  assign beats      = beats_reg;

endmodule

// File: tb/tb_reg_addr_sequencer.sv
module tb_reg_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic [1:0]  sel;
  logic        load;
  logic        out_ready;
  logic [3:0]  addr;
  logic        addr_valid;
  logic        last;
  logic        busy;
  logic        empty_list;
  logic [4:0]  beats;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_addr_sequencer #(.AW(4), .IRW(32), .PC_IDX(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .ir         (ir),
    .sel        (sel),
    .load       (load),
    .out_ready  (out_ready),
    .addr       (addr),
    .addr_valid (addr_valid),
    .last       (last),
    .busy       (busy),
    .empty_list (empty_list),
    .beats      (beats)
  );

  // One request: expected addresses packed as nibbles, beat k at addrs[4k+:4].
  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] ir;
    logic [4:0]  nbeats;
    logic [63:0] addrs;
    logic        empty;
    logic [4:0]  stall_at;   // beat index held off 3 clocks; 31 = none
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [3:0] ea;
    @(negedge clk);
    sel = v.sel; ir = v.ir; load = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    ir = 32'hDEAD_BEEF; sel = 2'd1;   // changes while busy must not matter
    for (int k = 0; k < int'(v.nbeats); k++) begin
      ea = v.addrs[4*k +: 4];
      if (k == int'(v.stall_at)) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk("stall_addr", 32'(addr), 32'(ea));
          chk("stall_valid", 32'(addr_valid), 32'd1);
          chk("stall_beats", 32'(beats), 32'(k));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("v%0d_valid_b%0d", id, k), 32'(addr_valid), 32'd1);
      chk($sformatf("v%0d_addr_b%0d", id, k), 32'(addr), 32'(ea));
      chk($sformatf("v%0d_last_b%0d", id, k), 32'(last), 32'(k == int'(v.nbeats) - 1));
      chk($sformatf("v%0d_beats_b%0d", id, k), 32'(beats), 32'(k));
      chk($sformatf("v%0d_busy_b%0d", id, k), 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk($sformatf("v%0d_busy_end", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d_valid_end", id), 32'(addr_valid), 32'd0);
    chk($sformatf("v%0d_last_end", id), 32'(last), 32'd0);
    chk($sformatf("v%0d_beats_end", id), 32'(beats), 32'(v.nbeats));
    chk($sformatf("v%0d_empty_end", id), 32'(empty_list), 32'(v.empty));
    $display("vector %0d sel=%0d ir=%08h beats=%0d empty=%0b", id, v.sel, v.ir, beats, empty_list);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] asc3, lst_dflt, all_dflt;
    asc3 = 64'h0000_0000_0000_0F20;
`ifdef REG_ADDR_DESCEND_EN
    lst_dflt = 64'h0000_0000_0000_002F;
    all_dflt = 64'h0123_4567_89AB_CDEF;
`else
    lst_dflt = asc3;
    all_dflt = 64'hFEDC_BA98_7654_3210;
`endif
    vecs[0] = '{2'd0, 32'h0003_5000, 5'd1,  64'h3,    1'b0, 5'd31};
    vecs[1] = '{2'd1, 32'h0003_5000, 5'd1,  64'h5,    1'b0, 5'd31};
    vecs[2] = '{2'd2, 32'h0003_5000, 5'd1,  64'hF,    1'b0, 5'd31};
    vecs[3] = '{2'd3, 32'h0000_8005, 5'd3,  lst_dflt, 1'b0, 5'd31};
    vecs[4] = '{2'd3, 32'h0000_8005, 5'd3,  lst_dflt, 1'b0, 5'd1};
    vecs[5] = '{2'd3, 32'h0000_0000, 5'd1,  64'hF,    1'b1, 5'd31};
    vecs[6] = '{2'd3, 32'h0080_8005, 5'd3,  asc3,     1'b0, 5'd31};
    vecs[7] = '{2'd3, 32'h0000_FFFF, 5'd16, all_dflt, 1'b0, 5'd31};
    vecs[8] = '{2'd3, 32'h0000_0040, 5'd1,  64'h6,    1'b0, 5'd31};
    vecs[9] = '{2'd0, 32'hFFF7_AFFF, 5'd1,  64'h7,    1'b0, 5'd31};

    reset = 1'b1; load = 1'b0; out_ready = 1'b0; sel = 2'd0; ir = '0;
    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(empty_list), 32'd0);
    chk("rst_beats", 32'(beats), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Load held high while busy, and on the cycle of the final handshake.
    @(negedge clk);
    sel = 2'd3; ir = 32'h0080_8005; load = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    sel = 2'd0; ir = 32'h0003_5000;   // competing load stays asserted
    for (int s = 0; s < 2; s++) begin
      chk("busyload_addr", 32'(addr), 32'd0);
      chk("busyload_beats", 32'(beats), 32'd0);
      chk("busyload_last", 32'(last), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("busyload_addr2", 32'(addr), 32'd2);
    @(negedge clk);
    chk("busyload_addr15", 32'(addr), 32'd15);
    chk("busyload_last15", 32'(last), 32'd1);
    @(negedge clk);
    chk("finalhs_busy", 32'(busy), 32'd0);
    chk("finalhs_valid", 32'(addr_valid), 32'd0);
    chk("finalhs_beats", 32'(beats), 32'd3);
    @(negedge clk);
    load = 1'b0;
    chk("nextload_busy", 32'(busy), 32'd1);
    chk("nextload_addr", 32'(addr), 32'd3);
    chk("nextload_last", 32'(last), 32'd1);
    chk("nextload_beats", 32'(beats), 32'd0);
    @(negedge clk);
    chk("nextload_done", 32'(beats), 32'd1);
    $display("sequence load-while-busy done");

    // Reset in the middle of a list.
    @(negedge clk);
    sel = 2'd3; ir = 32'h0000_FFFF; load = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("midlist_beats", 32'(beats), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", 32'(addr_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_beats", 32'(beats), 32'd0);
    chk("midrst_last", 32'(last), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_idle_valid", 32'(addr_valid), 32'd0);
    $display("sequence reset-mid-list done");
    run_vec(10, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
